// File: rtl/cpu_ex_muldiv.sv
// Iterative EX-stage multiply/divide unit with architectural HI/LO registers.
// Optional macro CPU_MULDIV_EARLY_OUT_EN: multiply leaves early once the multiplier is exhausted.
module cpu_ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_MFHI = 3'b110;
    localparam logic [2:0] OP_MFLO = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state_q, state_d;

    logic [2*DATA_W-1:0] acc_q;     // product accumulator
    logic [2*DATA_W-1:0] mcand_q;   // shifted multiplicand; low half holds the divisor
    logic [DATA_W-1:0]   opq_q;     // multiplier shifter, or dividend -> quotient
    logic [DATA_W-1:0]   rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q, neg_r, div_q, div0_q;
    logic [DATA_W-1:0]   hi_q, lo_q, rd_data_q;
    logic                rd_valid_q, done_q;

    logic                accept, signed_op, last_iter, early_out, fits;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     rem_sh;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, hi_res, lo_res;

    assign accept    = req_valid & req_ready & ~flush;
    assign signed_op = ~req_op[0];
    assign a_mag     = (signed_op && req_a[DATA_W-1]) ? -req_a : req_a;
    assign b_mag     = (signed_op && req_b[DATA_W-1]) ? -req_b : req_b;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef CPU_MULDIV_EARLY_OUT_EN
    assign early_out = (opq_q[DATA_W-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif

    // Restoring step: the running remainder stays below the divisor, so W bits hold it.
    assign rem_sh = {rem_q, opq_q[DATA_W-1]};
    assign fits   = (rem_sh >= {1'b0, mcand_q[DATA_W-1:0]});

    assign prod   = neg_q ? -acc_q : acc_q;
    assign quo    = neg_q ? -opq_q : opq_q;
    assign rem    = neg_r ? -rem_q : rem_q;
    assign hi_res = div_q ? rem : prod[2*DATA_W-1:DATA_W];
    assign lo_res = div_q ? (div0_q ? '1 : quo) : prod[DATA_W-1:0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !req_op[2]) state_d = req_op[1] ? DIV : MUL;
            MUL:  if (last_iter || early_out) state_d = FIX;
            DIV:  if (last_iter) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            opq_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_q      <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            if (!flush) begin
                case (state_q)
                    IDLE: if (accept) begin
                        case (req_op)
                            OP_MTHI: hi_q <= req_a;
                            OP_MTLO: lo_q <= req_a;
                            OP_MFHI, OP_MFLO: begin
                                rd_data_q  <= req_op[0] ? lo_q : hi_q;
                                rd_valid_q <= 1'b1;
                            end
                            default: begin
                                acc_q   <= '0;
                                rem_q   <= '0;
                                cnt_q   <= '0;
                                opq_q   <= req_op[1] ? a_mag : b_mag;
                                mcand_q <= {{DATA_W{1'b0}}, (req_op[1] ? b_mag : a_mag)};
                                neg_q   <= signed_op & (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
                                neg_r   <= signed_op & req_a[DATA_W-1];
                                div_q   <= req_op[1];
                                div0_q  <= (req_b == '0);
                            end
                        endcase
                    end
                    MUL: begin
                        if (opq_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q <= mcand_q << 1;
                        opq_q   <= opq_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    DIV: begin
                        rem_q <= fits ? (rem_sh[DATA_W-1:0] - mcand_q[DATA_W-1:0])
                                      : rem_sh[DATA_W-1:0];
                        opq_q <= {opq_q[DATA_W-2:0], fits};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    FIX: begin
                        hi_q   <= hi_res;
                        lo_q   <= lo_res;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_cpu_ex_muldiv.sv
// Self-checking bench for cpu_ex_muldiv: directed boundary cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_cpu_ex_muldiv;

    localparam int W = 32;
`ifdef CPU_MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, MFHI = 3'b110, MFLO = 3'b111;

    logic         clk = 1'b0;
    logic         clr_n, flush, req_valid;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         req_ready, busy, done, rd_valid;
    logic [W-1:0] hi, lo, rd_data;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi, m_lo;

    cpu_ex_muldiv #(.DATA_W(W)) dut (
        .clk(clk), .clr_n(clr_n), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the architectural HI/LO pair.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned p;
        int              qa, qb;
        case (op)
            MULT: begin
                sa = $signed(a); sb = $signed(b);
                p = sa * sb;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            DIV: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 0;
                end else begin
                    qa = $signed(a); qb = $signed(b);
                    m_lo = qa / qb; m_hi = qa % qb;
                end
            end
            DIVU: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
        logic [W-1:0] bm;
        int           idx;
        if (op[1] || !EARLY) return W + 1;
        bm  = (!op[0] && b[W-1]) ? -b : b;
        idx = 0;
        for (int i = 0; i < W; i++) if (bm[i]) idx = i;
        return idx + 2;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        check("ready_wait", req_ready, 1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int           n;
        bit           stall_ok;
        logic [W-1:0] rd_exp;
        wait_ready();
        rd_exp = op[0] ? m_lo : m_hi;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick();
        req_valid = 1'b0;
        model(op, a, b);
        if (op[2]) begin
            if (op[1]) begin
                check("mf_valid", rd_valid, 1);
                check("mf_data", rd_data, rd_exp);
            end else begin
                check("mt_hi", hi, m_hi);
                check("mt_lo", lo, m_lo);
            end
        end else begin
            n = 0; stall_ok = 1'b1;
            while (!done && n < 40) begin
                stall_ok &= busy & ~req_ready;
                tick(); n++;
            end
            check("latency", n, exp_lat(op, b));
            check("stall", stall_ok, 1);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("ready_after", {busy, req_ready}, 2'b01);
            tick();
            check("done_pulse", done, 0);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  n;
        bit  seen;
        clr_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_flags", {busy, done, rd_valid, req_ready}, 4'b0001);
        @(negedge clk) clr_n = 1'b1;
        tick();

        // Directed cases from the boundary list.
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t1_hi", hi, 32'hFFFF_FFFE);
        check("t1_lo", lo, 32'h0000_0001);
        run_op(MULT, 32'hFFFF_FFFD, 32'd7);
        check("t2_hi", hi, 32'hFFFF_FFFF);
        check("t2_lo", lo, 32'hFFFF_FFEB);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2);
        check("t3_lo", lo, 32'hFFFF_FFFD);
        check("t3_hi", hi, 32'hFFFF_FFFF);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("t3_ovf_lo", lo, 32'h8000_0000);
        check("t3_ovf_hi", hi, 32'h0000_0000);
        run_op(DIVU, 32'h0000_1234, 32'd0);
        check("t4_lo", lo, 32'hFFFF_FFFF);
        check("t4_hi", hi, 32'h0000_1234);
        run_op(MULT, 32'd0, 32'h1234_5678);
        run_op(DIV, 32'h8000_0000, 32'd0);

        // MFLO held behind a running DIVU.
        run_op(MTLO, 32'h55, 32'd0);
        wait_ready();
        req_valid = 1'b1; req_op = DIVU; req_a = 32'd100; req_b = 32'd7;
        tick();
        model(DIVU, 32'd100, 32'd7);
        req_op = MFLO; req_a = '0; req_b = '0;
        n = 0; seen = 1'b0;
        while (!done && n < 40) begin seen |= rd_valid; tick(); n++; end
        check("t5_latency", n, W + 1);
        check("t5_no_early_rd", seen | rd_valid, 0);
        tick();
        req_valid = 1'b0;
        check("t5_rd_valid", rd_valid, 1);
        check("t5_rd_data", rd_data, 32'h0000_000E);
        check("t5_hi", hi, 32'h0000_0002);
        tick();
        check("t5_rd_pulse", rd_valid, 0);

        // Flush of a running multiply.
        run_op(MTHI, 32'h1111, 32'd0);
        run_op(MTLO, 32'h2222, 32'd0);
        wait_ready();
        req_valid = 1'b1; req_op = MULTU; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_state", {busy, done, req_ready}, 3'b001);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin seen |= done; tick(); end
        check("flush_no_done", seen, 0);
        check("flush_hi", hi, m_hi);
        check("flush_lo", lo, m_lo);

        // Flush on the accept edge drops the request.
        req_valid = 1'b1; req_op = MTHI; req_a = 32'hDEAD; flush = 1'b1;
        tick();
        check("flush_mt_drop", hi, m_hi);
        req_op = MULT; req_a = 32'd3; req_b = 32'd5;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_mul_drop", {busy, req_ready}, 2'b01);

        // Asynchronous reset in the middle of a divide.
        run_op(MTHI, 32'hAAAA_0001, 32'd0);
        wait_ready();
        req_valid = 1'b1; req_op = DIV; req_a = 32'd1000; req_b = 32'd3;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        clr_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_flags", {busy, req_ready}, 2'b01);
        m_hi = '0; m_lo = '0;
        @(negedge clk) clr_n = 1'b1;
        tick();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
